// File: rtl/regfile_pkg.sv
// regfile_pkg: constants and types shared by the register file, ALU and decoder.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default register width and register count
//   word_t                        : one data word at the default width
//   addr_width()                  : address width for a given depth, at least 1
package regfile_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 8;

    typedef logic [DEFAULT_WIDTH-1:0] word_t;

    function automatic int addr_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// regfile_rdport: one combinational read port of the register file.
//   rd_addr            : read address
//   mem, pend          : register contents and pending bits from the top
//   wr_en/addr/data    : current write port, used only for same-cycle forwarding
//   rd_data, busy      : selected word and its pending bit (zero when out of range)
// Forwarding is built only when REGFILE_BYPASS_EN is defined.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW = addr_width(DEPTH)
) (
    input  logic [AW-1:0]    rd_addr,
    input  logic [WIDTH-1:0] mem [DEPTH],
    input  logic [DEPTH-1:0] pend,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy
);

    logic [WIDTH-1:0] stored;
    logic             pend_bit;

    // An address at or beyond DEPTH matches no entry, so it reads as zero, not busy.
    always_comb begin
        stored   = '0;
        pend_bit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == AW'(i)) begin
                stored   = mem[i];
                pend_bit = pend[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic hit;
    assign hit     = wr_en && (32'(wr_addr) < DEPTH) && (wr_addr == rd_addr);
    assign rd_data = hit ? wr_data : stored;
    assign busy    = hit ? 1'b0 : pend_bit;
`else
    logic unused_wr;
    assign unused_wr = ^{wr_en, wr_addr, wr_data};
    assign rd_data   = stored;
    assign busy      = pend_bit;
`endif

endmodule

// File: rtl/register_file.sv
// register_file: DEPTH x WIDTH register file, one write port, two read ports, pending bits.
//   clk, rst (async, active-high)
//   wr_en/wr_addr/wr_data      : writeback port; an out-of-range address raises wr_err next cycle
//   rd_addr_a/b -> rd_data_a/b : combinational reads, busy_a/b give the pending bit
//   lock_en/lock_addr          : mark a register pending until it is written
//   q                          : all registers, register i at q[WIDTH*i +: WIDTH]
// Optional macro REGFILE_BYPASS_EN forwards a same-cycle write to a matching read.
module register_file
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW = addr_width(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic [AW-1:0]          rd_addr_a,
    input  logic [AW-1:0]          rd_addr_b,
    output logic [WIDTH-1:0]       rd_data_a,
    output logic [WIDTH-1:0]       rd_data_b,
    input  logic                   lock_en,
    input  logic [AW-1:0]          lock_addr,
    output logic                   busy_a,
    output logic                   busy_b,
    output logic [WIDTH*DEPTH-1:0] q,
    output logic                   wr_err
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] pend;
    logic             wr_ok;
    logic             lock_ok;

    assign wr_ok   = wr_en && (32'(wr_addr) < DEPTH);
    assign lock_ok = lock_en && (32'(lock_addr) < DEPTH);

    // The lock assignment follows the write-clear so a simultaneous lock leaves the bit set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            pend   <= '0;
            wr_err <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_ok && wr_addr == AW'(i)) begin
                    mem[i]  <= wr_data;
                    pend[i] <= 1'b0;
                end
                if (lock_ok && lock_addr == AW'(i)) pend[i] <= 1'b1;
            end
            wr_err <= wr_en && !wr_ok;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_q
        assign q[WIDTH*g +: WIDTH] = mem[g];
    end

    regfile_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rd_a (
        .rd_addr (rd_addr_a),
        .mem     (mem),
        .pend    (pend),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rd_data_a),
        .busy    (busy_a)
    );

    regfile_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rd_b (
        .rd_addr (rd_addr_b),
        .mem     (mem),
        .pend    (pend),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rd_data_b),
        .busy    (busy_b)
    );

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed and random checks of register_file (DEPTH=6) against an array model.
module tb_register_file;
    import regfile_pkg::*;

    localparam int W  = 16;
    localparam int D  = 6;
    localparam int AW = 3;
    localparam int QW = W * D;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en, lock_en;
    logic [AW-1:0] wr_addr, rd_addr_a, rd_addr_b, lock_addr;
    logic [W-1:0]  wr_data, rd_data_a, rd_data_b;
    logic          busy_a, busy_b, wr_err;
    logic [QW-1:0] q;

    register_file #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .lock_en   (lock_en),
        .lock_addr (lock_addr),
        .busy_a    (busy_a),
        .busy_b    (busy_b),
        .q         (q),
        .wr_err    (wr_err)
    );

    always #5 clk = ~clk;

    word_t m_mem [8];
    bit    m_pend [8];
    bit    m_err;
    int    n_total = 0;
    int    n_bad   = 0;

    task automatic chk(input string tag, input logic [QW-1:0] got, input logic [QW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit fwd(input logic [AW-1:0] a);
        return BYP && wr_en && int'(wr_addr) < D && wr_addr == a;
    endfunction

    function automatic word_t exp_rd(input logic [AW-1:0] a);
        if (int'(a) >= D) return '0;
        if (fwd(a)) return wr_data;
        return m_mem[a];
    endfunction

    function automatic bit exp_busy(input logic [AW-1:0] a);
        if (int'(a) >= D || fwd(a)) return 1'b0;
        return m_pend[a];
    endfunction

    function automatic logic [QW-1:0] exp_q();
        logic [QW-1:0] r;
        for (int i = 0; i < D; i++) r[W*i +: W] = m_mem[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    task automatic model_edge();
        if (wr_en && int'(wr_addr) < D) begin
            m_mem[wr_addr]  = wr_data;
            m_pend[wr_addr] = 1'b0;
        end
        if (lock_en && int'(lock_addr) < D) m_pend[lock_addr] = 1'b1;
        m_err = wr_en && int'(wr_addr) >= D;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rd_a"}, QW'(rd_data_a), QW'(exp_rd(rd_addr_a)));
        chk({tag, ".rd_b"}, QW'(rd_data_b), QW'(exp_rd(rd_addr_b)));
        chk({tag, ".busy_a"}, QW'(busy_a), QW'(exp_busy(rd_addr_a)));
        chk({tag, ".busy_b"}, QW'(busy_b), QW'(exp_busy(rd_addr_b)));
        chk({tag, ".q"}, q, exp_q());
        chk({tag, ".wr_err"}, QW'(wr_err), QW'(m_err));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        if (rst) model_reset(); else model_edge();
        #1;
        check_all({tag, "@edge"});
    endtask

    task automatic drive(input string tag, input logic we, input logic [AW-1:0] wa,
                         input logic [W-1:0] wd, input logic le, input logic [AW-1:0] la,
                         input logic [AW-1:0] ra, input logic [AW-1:0] rb);
        @(negedge clk);
        wr_en = we; wr_addr = wa; wr_data = wd;
        lock_en = le; lock_addr = la;
        rd_addr_a = ra; rd_addr_b = rb;
        #1;
        check_all(tag);
    endtask

    logic [QW-1:0] q_before;

    initial begin
        rst = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        lock_en = 1'b0; lock_addr = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        model_reset();
        #1;
        check_all("por");
        @(negedge clk);
        rst = 1'b0;

        // Fill some state, then reset between edges.
        drive("pre1", 1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd0, 3'd1, 3'd0);
        tick("pre1");
        drive("pre2", 1'b1, 3'd0, 16'h5555, 1'b0, 3'd0, 3'd1, 3'd0);
        tick("pre2");
        @(negedge clk);
        wr_en = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst.q", q, '0);
        chk("async_rst.busy_b", QW'(busy_b), '0);
        chk("async_rst.wr_err", QW'(wr_err), '0);
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;

        drive("beef_wr", 1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0, 3'd0, 3'd0);
        tick("beef_wr");
        drive("beef_rd", 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd3, 3'd0);
        chk("beef.rd_a", QW'(rd_data_a), QW'(16'hBEEF));
        chk("beef.q3", QW'(q[63:48]), QW'(16'hBEEF));

        drive("fwd5", 1'b1, 3'd5, 16'h1234, 1'b0, 3'd0, 3'd0, 3'd5);
        chk("fwd5.rd_b", QW'(rd_data_b), BYP ? QW'(16'h1234) : '0);
        tick("fwd5");
        chk("fwd5.after", QW'(rd_data_b), QW'(16'h1234));

        drive("lock2", 1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 3'd2, 3'd0);
        tick("lock2");
        drive("lock2_idle", 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd2, 3'd0);
        chk("lock2.busy", QW'(busy_a), QW'(1));
        drive("wr2", 1'b1, 3'd2, 16'h0022, 1'b0, 3'd0, 3'd2, 3'd0);
        chk("wr2.busy_pre", QW'(busy_a), BYP ? '0 : QW'(1));
        tick("wr2");
        chk("wr2.busy_post", QW'(busy_a), '0);
        drive("lockwr2", 1'b1, 3'd2, 16'h0033, 1'b1, 3'd2, 3'd2, 3'd2);
        tick("lockwr2");
        drive("lockwr2_idle", 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd2, 3'd2);
        chk("lockwr2.busy", QW'(busy_a), QW'(1));
        chk("lockwr2.data", QW'(rd_data_b), QW'(16'h0033));

        q_before = q;
        drive("bad7", 1'b1, 3'd7, 16'hDEAD, 1'b1, 3'd6, 3'd7, 3'd6);
        chk("bad7.rd_a", QW'(rd_data_a), '0);
        tick("bad7");
        chk("bad7.q", q, q_before);
        chk("bad7.err", QW'(wr_err), QW'(1));
        drive("bad7_idle", 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd7, 3'd0);
        tick("bad7_idle");
        chk("bad7.err_clear", QW'(wr_err), '0);
        chk("bad7.rd_a_idle", QW'(rd_data_a), '0);

        drive("lock4", 1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 3'd4, 3'd0);
        tick("lock4");
        chk("lock4.busy", QW'(busy_a), QW'(1));
        @(negedge clk);
        rst = 1'b1;
        lock_en = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h4444;
        #1;
        model_reset();
        chk("rst4.busy", QW'(busy_a), '0);
        tick("rst4_held");
        chk("rst4.q_held", QW'(q[79:64]), '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst4.q_released", QW'(q[79:64]), '0);
        tick("rst4_wr");
        chk("rst4.q_written", QW'(q[79:64]), QW'(16'h4444));
        chk("rst4.busy_after", QW'(busy_a), '0);

        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] ra;
            ra = AW'($urandom_range(0, 7));
            drive("rand", $urandom_range(0, 3) != 0, AW'($urandom_range(0, 7)), W'($urandom),
                  $urandom_range(0, 3) == 0, AW'($urandom_range(0, 7)), ra,
                  ($urandom_range(0, 4) == 0) ? ra : AW'($urandom_range(0, 7)));
            if (rd_addr_a == rd_addr_b) chk("rand.same_port", QW'(rd_data_a), QW'(rd_data_b));
            tick("rand");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
